// File: rtl/conv_ctrl.sv
// ============================================================================
// Module   : conv_ctrl
// Purpose  : Raster-order convolution window sequencer with serial MAC and
//            valid/ready result hand-off. Optional macro CONV_CTRL_RELU_EN
//            clamps negative results to zero on the result port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_ctrl #(
    parameter int weight_width  = 2,
    parameter int weight_height = 2,
    parameter int img_width     = 4,
    parameter int img_height    = 4,
    parameter int padding       = 0,
    parameter int stride        = 1,
    parameter int bitwidth      = 3,
    parameter int acc_width     = 16
) (
    input  logic                 clk_en,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 conv_on,
    output logic [31:0]          anchor_l,
    output logic [31:0]          anchor_c,
    output logic [3:0]           buf_l,
    output logic [3:0]           buf_c,
    input  logic [bitwidth-1:0]  img_cal,
    input  logic [bitwidth-1:0]  wei_cal,
    output logic [acc_width-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [15:0]          result_l,
    output logic [15:0]          result_c
);

    localparam int c_result_width  = (img_width - weight_width + 2*padding) / stride + 1;
    localparam int c_result_height = (img_height - weight_height + 2*padding) / stride + 1;
    localparam int c_taps          = weight_width * weight_height;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MAC  = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 r_state;
    logic [8:0]             r_k;
    logic [15:0]            r_out_row;
    logic [15:0]            r_out_col;
    logic [acc_width-1:0]   r_acc;

    logic signed [2*bitwidth-1:0] w_img_ext;
    logic signed [2*bitwidth-1:0] w_wei_ext;
    logic signed [2*bitwidth-1:0] w_prod;
    logic signed [acc_width-1:0]  w_prod_ext;
    logic [acc_width-1:0]         w_acc_next;
    logic [acc_width-1:0]         w_result_next;
    logic                         w_last_k;
    logic                         w_last_col;
    logic                         w_last_pos;

    assign w_img_ext  = (2*bitwidth)'($signed(img_cal));
    assign w_wei_ext  = (2*bitwidth)'($signed(wei_cal));
    assign w_prod     = w_img_ext * w_wei_ext;
    assign w_prod_ext = acc_width'(w_prod);
    // First tap of each window restarts the sum instead of adding to it
    assign w_acc_next = ((r_k == 9'd0) ? '0 : r_acc) + w_prod_ext;

`ifdef CONV_CTRL_RELU_EN
    assign w_result_next = w_acc_next[acc_width-1] ? '0 : w_acc_next;
`else
    assign w_result_next = w_acc_next;
`endif

    assign w_last_k   = (r_k == 9'(c_taps - 1));
    assign w_last_col = (r_out_col == 16'(c_result_width - 1));
    assign w_last_pos = w_last_col && (r_out_row == 16'(c_result_height - 1));

    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_acc        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            conv_on      <= 1'b0;
            anchor_l     <= '0;
            anchor_c     <= '0;
            buf_l        <= '0;
            buf_c        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            result_l     <= '0;
            result_c     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out_row <= '0;
                    r_out_col <= '0;
                    r_acc     <= '0;
                    anchor_l  <= '0;
                    anchor_c  <= '0;
                    if (start) begin
                        r_state <= S_LOAD;
                        busy    <= 1'b1;
                        conv_on <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_k     <= '0;
                    buf_l   <= '0;
                    buf_c   <= '0;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    if (w_last_k) begin
                        r_state      <= S_OUT;
                        conv_on      <= 1'b0;
                        result_valid <= 1'b1;
                        result       <= w_result_next;
                        result_l     <= r_out_row;
                        result_c     <= r_out_col;
                    end else begin
                        r_k <= r_k + 9'd1;
                        if (buf_c == 4'(weight_width - 1)) begin
                            buf_c <= '0;
                            buf_l <= buf_l + 4'd1;
                        end else begin
                            buf_c <= buf_c + 4'd1;
                        end
                    end
                end
                S_OUT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (w_last_pos) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            conv_on <= 1'b1;
                            if (w_last_col) begin
                                r_out_col <= '0;
                                anchor_c  <= '0;
                                r_out_row <= r_out_row + 16'd1;
                                anchor_l  <= anchor_l + 32'(stride);
                            end else begin
                                r_out_col <= r_out_col + 16'd1;
                                anchor_c  <= anchor_c + 32'(stride);
                            end
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/conv_ctrl.md
# conv_ctrl

Sequencer for the convolution window buffer: walks the output feature map in raster order and drives anchor and window-index signals plus `conv_on` to the window buffer. Serially multiply-accumulates the returned `img_cal`/`wei_cal` pairs into one result per output position, then hands each result downstream over a valid/ready handshake. Sits between the layer-level control (start/done) and the window buffer / result store.

## Interface

- `weight_width`, 2, kernel columns (≤16)
- `weight_height`, 2, kernel rows (≤16)
- `img_width`, 4, input columns
- `img_height`, 4, input rows
- `padding`, 0, zero border per side; the window buffer applies it, this block only sizes the sweep
- `stride`, 1, anchor step in rows and columns
- `bitwidth`, 3, signed operand width
- `acc_width`, 16, signed accumulator/result width; must be ≥ 2*bitwidth + ceil(log2(weight_width*weight_height))
- `result_width`, (img_width-weight_width+2*padding)/stride+1, output columns (derived)
- `result_height`, (img_height-weight_height+2*padding)/stride+1, output rows (derived)

Ports:
- `clk_en` in 1: the single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a full feature-map pass; sampled only in IDLE
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse after the last result is accepted
- `conv_on` out 1: window-buffer load enable
- `anchor_l` out 32: window top row, equal to out_row*stride
- `anchor_c` out 32: window left column, equal to out_col*stride
- `buf_l` out 4: window row being read
- `buf_c` out 4: window column being read
- `img_cal` in bitwidth: buffered pixel at (`buf_l`,`buf_c`), signed
- `wei_cal` in bitwidth: weight at (`buf_l`,`buf_c`), signed
- `result` out acc_width: accumulated dot product
- `result_valid` out 1: result available
- `result_ready` in 1: downstream accepts
- `result_l` out 16: output row of `result`
- `result_c` out 16: output column of `result`

## Operation

- FSM states: IDLE, LOAD, MAC, OUT, DONE.
- IDLE:
  - `start`=1 moves to LOAD.
  - out_row, out_col and the accumulator are cleared.
- LOAD:
  - One cycle; `conv_on`=1 with the anchors stable.
  - The buffer captures the window at the end of this cycle.
  - Window index k is cleared to 0.
- MAC:
  - Lasts weight_width*weight_height cycles; `conv_on` stays 1 and the anchors do not change.
  - `buf_l` = k / weight_width, `buf_c` = k % weight_width, scanned row-major.
  - Each edge: acc ← (k==0 ? 0 : acc) + sign-extend(img_cal*wei_cal).
  - The product is 2*bitwidth signed and is sign-extended to acc_width. Overflow wraps; no saturation.
  - After the last k, moves to OUT.
- OUT:
  - `conv_on`=0, `result_valid`=1.
  - `result`, `result_l`, `result_c` are held stable until `result_ready`=1.
  - On accept, out_col advances. At result_width-1, out_col wraps to 0 and out_row advances.
  - If the accepted result was (result_height-1, result_width-1), moves to DONE; otherwise to LOAD.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- Reset values (asynchronous, while `rst_n`=0):
  - all outputs 0
  - state IDLE, counters 0, accumulator 0
- Reset asserted mid-pass aborts immediately. No `done` is issued, and the next pass needs a fresh `start`.

## Timing

- Count cycles from the edge at which `start` is sampled (edge 0):
  - LOAD runs in cycle 1.
  - MAC runs in cycles 2 to W*H+1.
  - `result_valid` first rises in cycle W*H+2.
- With `result_ready` held high, each output takes W*H+2 cycles.
- A full pass takes result_width*result_height*(W*H+2) cycles, followed by one DONE cycle.
- Backpressure adds one cycle per cycle `result_ready` is low, with no loss or duplication of results.
- `busy` rises the cycle after the `start` edge and falls in the cycle after DONE.

## Configuration

- `CONV_CTRL_RELU_EN`:
  - Defined: `result` presents max(acc, 0); a negative accumulation shows as 0.
  - Undefined: `result` presents the raw signed accumulator.
- The accumulator itself is identical in both builds.

## Test plan

- Defaults, all pixels 1, all weights 1, `result_ready` high:
  - 9 results of value 4, in order (0,0)…(2,2).
  - `done` pulses in cycle 55 after `start`.
- Pixels 3'b111 (-1), weights 3'b011 (3):
  - Each result is -12 (16'hFFF4) without the macro and 0 with `CONV_CTRL_RELU_EN`.
- `result_ready` low for 5 cycles on the first result:
  - `result`, `result_l`, `result_c` stay stable and `conv_on` stays 0.
  - The second result arrives exactly 5 cycles later than in the unstalled run.
- stride=2, img 5x5, kernel 3x3:
  - Anchors are (0,0), (0,2), (2,0), (2,2) in that order.
  - Each output spends 9 MAC cycles, and `buf_l`/`buf_c` sweep (0,0)…(2,2).
- `rst_n` pulsed low during the MAC of the 4th output:
  - All outputs go to 0 at once and no `done` follows.
  - A new `start` restarts at (0,0).
- `start` held high throughout a pass: exactly one pass per rising entry into IDLE, and no extra results.
